pattern_bit_serializer: RTL and testbench

Upstream feeder for the serial pattern detector. Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on nwbit. Consecutive words are emitted with no idle gap, so the detector sees a continuous bit stream across word boundaries.

---
 rtl/pattern_bit_serializer.sv | 151 +++++++++++++++
 tb/tb_pattern_bit_serializer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pattern_bit_serializer.sv
// ============================================================================
// pattern_bit_serializer
// ----------------------------------------------------------------------------
// Upstream feeder for the serial pattern detector. Parallel words arrive over
// a valid/ready handshake and are shifted out MSB-first, one bit per clock, on
// nwbit. A new word can be taken during the last bit of the current frame, so
// back-to-back words form one continuous bit stream with no idle gap.
//
// Handshake: a word transfers on a rising clk edge where din_valid and
// din_ready are both 1. din_ready is high in IDLE and during the last bit of
// a frame. At all other times din/din_valid are ignored. din_ready never
// depends on din_valid.
//
// Optional feature (macro SERIALIZER_PARITY_EN):
//   defined   - an even-parity bit (XOR of the word) is appended after the
//               data bits; frame length is WIDTH+1.
//   undefined - no parity logic; frame length is WIDTH.
//
// Parameters:
//   WIDTH     data word width (2..32)
//   IDLE_BIT  value on nwbit when no frame bit is being emitted
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   din        in   parallel word to serialize
//   din_valid  in   din holds a word to be accepted
//   din_ready  out  a word can be accepted at the next rising edge
//   nwbit      out  serial bit stream
//   bit_valid  out  nwbit carries a frame bit this cycle
//   busy       out  a frame is being shifted out
//   word_done  out  one-cycle pulse during the last bit of a frame
// ============================================================================
module pattern_bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             nwbit,
    output logic             bit_valid,
    output logic             busy,
    output logic             word_done
);

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [FRAME_LEN-1:0] sr_q, sr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] load_word;
    logic                 last_bit;

    // Frame image loaded into the shift register; MSB leaves first.
`ifdef SERIALIZER_PARITY_EN
    assign load_word = {din, ^din};
`else
    assign load_word = din;
`endif

    assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    sr_d    = load_word;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    if (din_valid) begin
                        // Reload in place: first bit of the next word follows
                        // directly after this last bit.
                        sr_d  = load_word;
                        cnt_d = '0;
                    end else begin
                        sr_d    = '0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    sr_d  = {sr_q[FRAME_LEN-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode (registered state only; rst gates din_ready so no word is
    // offered while reset is held, and it returns as soon as rst falls)
    // ------------------------------------------------------------------------
    always_comb begin
        din_ready = 1'b0;
        nwbit     = IDLE_BIT;
        bit_valid = 1'b0;
        busy      = 1'b0;
        word_done = 1'b0;
        if (state_q == S_SHIFT) begin
            nwbit     = sr_q[FRAME_LEN-1];
            bit_valid = 1'b1;
            busy      = 1'b1;
            word_done = last_bit;
            din_ready = last_bit && !rst;
        end else begin
            din_ready = !rst;
        end
    end

endmodule

// File: tb/tb_pattern_bit_serializer.sv
// Directed bench for pattern_bit_serializer (WIDTH=8, IDLE_BIT=0).
module tb_pattern_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready, nwbit, bit_valid, busy, word_done;

    int n_cmp = 0;
    int n_err = 0;

    pattern_bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .nwbit     (nwbit),
        .bit_valid (bit_valid),
        .busy      (busy),
        .word_done (word_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame image, LSB-aligned in 9 bits: data bits, then the
    // hand-computed parity bit when parity is enabled.
    function automatic logic [8:0] frame(input logic [7:0] d, input logic par);
`ifdef SERIALIZER_PARITY_EN
        return {d, par};
`else
        return {1'b0, d};
`endif
    endfunction

    // Checks one full frame starting in its first bit cycle. During the last
    // bit, offers nxt if chain is set. jam toggles din/din_valid in cycles 2-6.
    task automatic shift_frame(input string tag, input logic [8:0] exp_bits,
                               input bit chain, input logic [7:0] nxt, input bit jam);
        for (int i = 0; i < FL; i++) begin
            if (i == 0) din_valid = 1'b0;
            if (jam && i >= 1 && i <= 5) begin
                din       = 8'h00;
                din_valid = ~din_valid;
            end
            if (i == FL - 1) begin
                din       = nxt;
                din_valid = chain;
            end
            chk({tag, "_nwbit"},     nwbit,     exp_bits[FL-1-i]);
            chk({tag, "_bit_valid"}, bit_valid, 1'b1);
            chk({tag, "_busy"},      busy,      1'b1);
            chk({tag, "_word_done"}, word_done, i == FL - 1);
            chk({tag, "_din_ready"}, din_ready, i == FL - 1);
            tick();
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_idle_nwbit"},     nwbit,     1'b0);
        chk({tag, "_idle_bit_valid"}, bit_valid, 1'b0);
        chk({tag, "_idle_busy"},      busy,      1'b0);
        chk({tag, "_idle_word_done"}, word_done, 1'b0);
        chk({tag, "_idle_din_ready"}, din_ready, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_nwbit",     nwbit,     1'b0);
        chk("rst_bit_valid", bit_valid, 1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_word_done", word_done, 1'b0);
        chk("rst_din_ready", din_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_din_ready", din_ready, 1'b1);

        // 1: single A5
        din = 8'hA5; din_valid = 1'b1;
        tick();
        shift_frame("t1_a5", frame(8'hA5, 1'b0), 1'b0, 8'h00, 1'b0);
        chk_idle("t1");
        tick();
        chk_idle("t1b");

        // 2: A5 then 5A back to back
        din = 8'hA5; din_valid = 1'b1;
        tick();
        shift_frame("t2_a5", frame(8'hA5, 1'b0), 1'b1, 8'h5A, 1'b0);
        shift_frame("t2_5a", frame(8'h5A, 1'b0), 1'b0, 8'h00, 1'b0);
        chk_idle("t2");

        // 3: FF with din/din_valid disturbed mid-frame
        din = 8'hFF; din_valid = 1'b1;
        tick();
        shift_frame("t3_ff", frame(8'hFF, 1'b0), 1'b0, 8'h00, 1'b1);
        chk_idle("t3");

        // 4: asynchronous reset during bit index 4 of A5
        din = 8'hA5; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_pre_nwbit", nwbit, 8'hA5 >> (7 - i) & 1'b1);
            tick();
        end
        chk("t4_bit4_nwbit", nwbit, 1'b0);
        chk("t4_bit4_valid", bit_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_nwbit",     nwbit,     1'b0);
        chk("t4_rst_bit_valid", bit_valid, 1'b0);
        chk("t4_rst_busy",      busy,      1'b0);
        chk("t4_rst_word_done", word_done, 1'b0);
        chk("t4_rst_din_ready", din_ready, 1'b0);
        @(posedge clk);
        #4 rst = 1'b0;
        #1;
        chk("t4_rel_din_ready", din_ready, 1'b1);
        chk("t4_rel_bit_valid", bit_valid, 1'b0);
        din = 8'h3C; din_valid = 1'b1;
        tick();
        shift_frame("t4_3c", frame(8'h3C, 1'b0), 1'b0, 8'h00, 1'b0);
        chk_idle("t4");

        // 5: 01 (parity 1 when enabled)
        din = 8'h01; din_valid = 1'b1;
        tick();
        shift_frame("t5_01", frame(8'h01, 1'b1), 1'b0, 8'h00, 1'b0);
        chk_idle("t5");

        // 6: 05 then 40 back to back; "101" spans the word boundary
        din = 8'h05; din_valid = 1'b1;
        tick();
        shift_frame("t6_05", frame(8'h05, 1'b0), 1'b1, 8'h40, 1'b0);
        shift_frame("t6_40", frame(8'h40, 1'b1), 1'b0, 8'h00, 1'b0);
        chk_idle("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
